// File: rtl/ibf_pkg.sv
// ibf_pkg: shared CRC constants, op encoding, FSM states and cell field offsets for the IBF programming engine.
package ibf_pkg;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_HASH, S_RD, S_WR, S_DONE, S_DUMP} state_e;
    // Cell layout is {key, sig, count} with the count in the LSBs.
    function automatic int sig_lsb(input int cnt_w);
        return cnt_w;
    endfunction
    function automatic int key_lsb(input int sig_w, input int cnt_w);
        return sig_w + cnt_w;
    endfunction
endpackage

// File: rtl/ibf_program_engine_if.sv
// ibf_program_engine_if: key input handshake, status and dump port bundle of the IBF programming engine.
interface ibf_program_engine_if #(
    parameter int KEY_W  = 32,
    parameter int IDX_W  = 12,
    parameter int CELL_W = 48
) ();
    logic              in_valid;
    logic              in_ready;
    logic [KEY_W-1:0]  in_key;
    logic              in_op;
    logic              done;
    logic              busy;
    logic              dump_start;
    logic              dump_valid;
    logic [IDX_W-1:0]  dump_addr;
    logic [CELL_W-1:0] dump_data;
    logic [31:0]       elem_count;
    logic              cnt_err;
    modport master (
        output in_valid, in_key, in_op, dump_start,
        input  in_ready, done, busy, dump_valid, dump_addr, dump_data, elem_count, cnt_err
    );
    modport slave (
        input  in_valid, in_key, in_op, dump_start,
        output in_ready, done, busy, dump_valid, dump_addr, dump_data, elem_count, cnt_err
    );
endinterface

// File: rtl/ibf_hash.sv
// ibf_hash: combinational key -> K cell indices plus signature, each index from a non-reflected CRC-32 of key^k.
module ibf_hash
    import ibf_pkg::*;
#(
    parameter int KEY_W = 32,
    parameter int SIG_W = 8,
    parameter int IDX_W = 12,
    parameter int CELLS = 4096,
    parameter int K     = 3
) (
    input  logic [KEY_W-1:0]          key_i,
    output logic [K-1:0][IDX_W-1:0]   idx_o,
    output logic [SIG_W-1:0]          sig_o
);
    function automatic logic [31:0] crc32(input logic [KEY_W-1:0] d);
        logic [31:0] c;
        c = CRC_INIT;
        for (int i = KEY_W - 1; i >= 0; i--) c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'd0);
        return c;
    endfunction
    function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] h);
        return IDX_W'((h >> (32 - IDX_W)) % 32'(CELLS));
    endfunction
    always_comb begin
        for (int k = 0; k < K; k++) idx_o[k] = to_idx(crc32(key_i ^ KEY_W'(k)));
        sig_o = SIG_W'(crc32(key_i));
    end
endmodule

// File: rtl/ibf_program_engine.sv
// ibf_program_engine: clears, programs (insert, or delete when IBF_DELETE_EN is defined) and dumps an on-chip IBF.
// Each distinct hashed cell of an element is read-modify-written exactly once through a single-port RAM.
module ibf_program_engine
    import ibf_pkg::*;
#(
    parameter int KEY_W = 32,
    parameter int SIG_W = 8,
    parameter int CNT_W = 8,
    parameter int CELLS = 4096,
    parameter int IDX_W = 12,
    parameter int K     = 3
) (
    input logic clk,
    input logic reset,
    ibf_program_engine_if.slave bus
);
    localparam int CELL_W = KEY_W + SIG_W + CNT_W;
    localparam int KL = key_lsb(SIG_W, CNT_W);
    localparam int SL = sig_lsb(CNT_W);
    localparam int KW = $clog2(K);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CELLS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        addr_q, addr_d, ram_addr, dump_addr_q;
    logic [K-1:0]            mask_q, mask_d, mask_h;
    logic [K-1:0][IDX_W-1:0] idx_q, idx_h;
    logic [SIG_W-1:0]        sig_q, sig_h;
    logic [KEY_W-1:0]        key_q;
    logic [KW-1:0]           k_sel;
    logic [CELL_W-1:0]       mem [CELLS];
    logic [CELL_W-1:0]       rd_q, wr_data;
    logic [CNT_W-1:0]        cnt_old, cnt_new;
    logic [31:0]             elem_q;
    logic                    accept, ram_we, del, upd_err, dump_valid_q, err_q;

    ibf_hash #(.KEY_W(KEY_W), .SIG_W(SIG_W), .IDX_W(IDX_W), .CELLS(CELLS), .K(K)) u_hash (
        .key_i(key_q),
        .idx_o(idx_h),
        .sig_o(sig_h)
    );

    assign accept = state_q == S_IDLE && bus.in_valid && !bus.dump_start;

`ifdef IBF_DELETE_EN
    logic op_q;
    always_ff @(posedge clk) if (accept) op_q <= bus.in_op;
    assign del = op_q == OP_DELETE;
`else
    logic unused_op;
    assign unused_op = bus.in_op;
    assign del = 1'b0;
`endif

    // An index is active only if no lower-numbered index hit the same cell.
    always_comb begin
        mask_h = '1;
        for (int k = 1; k < K; k++)
            for (int j = 0; j < k; j++)
                if (idx_h[j] == idx_h[k]) mask_h[k] = 1'b0;
        k_sel = '0;
        for (int k = K - 1; k >= 0; k--)
            if (mask_q[k]) k_sel = KW'(k);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        case (state_q)
            S_CLEAR, S_DUMP: begin
                addr_d  = addr_q == LAST ? '0 : addr_q + 1'b1;
                state_d = addr_q == LAST ? S_IDLE : state_q;
            end
            S_IDLE: begin
                addr_d  = '0;
                state_d = bus.dump_start ? S_DUMP : bus.in_valid ? S_HASH : S_IDLE;
            end
            S_HASH: begin
                mask_d  = mask_h;
                state_d = S_RD;
            end
            S_RD: state_d = S_WR;
            S_WR: begin
                mask_d  = mask_q & ~(K'(1) << k_sel);
                state_d = mask_d == '0 ? S_DONE : S_RD;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    assign cnt_old  = rd_q[CNT_W-1:0];
    assign cnt_new  = del ? cnt_old - 1'b1 : cnt_old + 1'b1;
    assign upd_err  = del ? cnt_old == '0 : &cnt_old;
    assign ram_addr = (state_q == S_RD || state_q == S_WR) ? idx_q[k_sel] : addr_q;
    assign ram_we   = state_q == S_CLEAR || state_q == S_WR;
    assign wr_data  = state_q == S_WR ? {rd_q[CELL_W-1:KL] ^ key_q, rd_q[KL-1:SL] ^ sig_q, cnt_new} : '0;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= wr_data;
        rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (accept) key_q <= bus.in_key;
        if (state_q == S_HASH) begin
            idx_q <= idx_h;
            sig_q <= sig_h;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            addr_q       <= '0;
            mask_q       <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            elem_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            dump_valid_q <= state_q == S_DUMP;
            if (state_q == S_DUMP) dump_addr_q <= addr_q;
            if (state_q == S_DONE) elem_q <= elem_q + 1'b1;
            if (state_q == S_WR && upd_err) err_q <= 1'b1;
        end
    end

    assign bus.in_ready   = state_q == S_IDLE;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.done       = state_q == S_DONE;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_valid_q ? rd_q : '0;
    assign bus.elem_count = elem_q;
    assign bus.cnt_err    = err_q;
endmodule

// File: tb/tb_ibf_program_engine.sv
// tb_ibf_program_engine: scoreboard bench for a 4096-cell and a 1-cell engine; dump beats are checked against a reference IBF model.
module tb_ibf_program_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0, v = 1'b0, op = 1'b0, ds = 1'b0;
    logic [31:0] key = '0;
    int tests = 0, fails = 0;
    int elems [2];
    logic [47:0] mdl [4096];
    logic [47:0] one_mdl;
    logic [59:0] exp_q [$];
    logic [59:0] got [$];
    logic [59:0] first_bad_got, first_bad_exp;
`ifdef IBF_DELETE_EN
    localparam bit DEL_EN = 1'b1;
`else
    localparam bit DEL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ibf_program_engine_if #(.KEY_W(32), .IDX_W(12), .CELL_W(48)) bb ();
    ibf_program_engine_if #(.KEY_W(32), .IDX_W(12), .CELL_W(48)) bo ();

    assign bb.in_valid = v & ~sel;
    assign bb.in_key = key;
    assign bb.in_op = op;
    assign bb.dump_start = ds & ~sel;
    assign bo.in_valid = v & sel;
    assign bo.in_key = key;
    assign bo.in_op = op;
    assign bo.dump_start = ds & sel;

    ibf_program_engine #(.CELLS(4096), .IDX_W(12), .K(3)) u_big (.clk(clk), .reset(reset), .bus(bb));
    ibf_program_engine #(.CELLS(1), .IDX_W(12), .K(3)) u_one (.clk(clk), .reset(reset), .bus(bo));

    logic rdy, dn, dv, bsy, err;
    logic [11:0] da;
    logic [47:0] dd;
    logic [31:0] ec;
    assign rdy = sel ? bo.in_ready : bb.in_ready;
    assign dn  = sel ? bo.done : bb.done;
    assign dv  = sel ? bo.dump_valid : bb.dump_valid;
    assign bsy = sel ? bo.busy : bb.busy;
    assign err = sel ? bo.cnt_err : bb.cnt_err;
    assign da  = sel ? bo.dump_addr : bb.dump_addr;
    assign dd  = sel ? bo.dump_data : bb.dump_data;
    assign ec  = sel ? bo.elem_count : bb.elem_count;

    function automatic logic [31:0] crc(input logic [31:0] d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF ^ d;
        for (int i = 0; i < 32; i++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        return c;
    endfunction

    task automatic clear_model();
        for (int a = 0; a < 4096; a++) mdl[a] = '0;
        one_mdl = '0;
        elems[0] = 0;
        elems[1] = 0;
    endtask

    task automatic apply(input logic s, input logic [31:0] kk, input logic o, output int d);
        logic [11:0] ix [3];
        logic [31:0] h;
        logic [7:0] sg;
        logic [47:0] c;
        bit dup;
        h = crc(kk);
        sg = h[7:0];
        d = 0;
        for (int k = 0; k < 3; k++) begin
            h = crc(kk ^ 32'(k));
            ix[k] = s ? 12'd0 : h[31:20];
            dup = 1'b0;
            for (int j = 0; j < k; j++) if (ix[j] == ix[k]) dup = 1'b1;
            if (!dup) begin
                d++;
                c = s ? one_mdl : mdl[ix[k]];
                c[47:16] = c[47:16] ^ kk;
                c[15:8] = c[15:8] ^ sg;
                c[7:0] = (o & DEL_EN) ? c[7:0] - 8'd1 : c[7:0] + 8'd1;
                if (s) one_mdl = c;
                else mdl[ix[k]] = c;
            end
        end
    endtask

    task automatic run_elem(input logic [31:0] kk, input logic o, output int d, output int done_off, output int rdy_off);
        for (int n = 0; n < 10000 && !rdy; n++) @(negedge clk);
        apply(sel, kk, o, d);
        elems[sel]++;
        key = kk;
        op = o;
        v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v = 1'b0;
        done_off = -1;
        rdy_off = -1;
        for (int j = 1; j <= 40; j++) begin
            if (dn && done_off < 0) done_off = j;
            if (rdy && rdy_off < 0) rdy_off = j;
            if (rdy_off >= 0) break;
            @(negedge clk);
        end
    endtask

    task automatic push_expected();
        for (int a = 0; a < (sel ? 1 : 4096); a++) exp_q.push_back(sel ? {12'd0, one_mdl} : {12'(a), mdl[a]});
    endtask

    task automatic run_dump(output int n, output int first, output int last);
        push_expected();
        n = 0;
        first = -1;
        last = -1;
        ds = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ds = 1'b0;
        for (int j = 1; j <= (sel ? 12 : 4110); j++) begin
            if (dv) begin
                got.push_back({da, dd});
                n++;
                if (first < 0) first = j;
                last = j;
            end
            @(negedge clk);
        end
    endtask

    function automatic int dump_bad();
        int bad = 0;
        logic [59:0] g, e;
        while (got.size() > 0) begin
            g = got.pop_front();
            e = exp_q.size() > 0 ? exp_q.pop_front() : ~g;
            if (g !== e) begin
                if (bad == 0) begin
                    first_bad_got = g;
                    first_bad_exp = e;
                end
                bad++;
            end
        end
        bad += exp_q.size();
        exp_q.delete();
        return bad;
    endfunction

    task automatic test_reset();
        int nb, no;
        repeat (3) @(negedge clk);
        tests++;
        if ({bb.in_ready, bb.busy, bb.done, bb.dump_valid, bb.cnt_err} !== 5'b01000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 01000", {bb.in_ready, bb.busy, bb.done, bb.dump_valid, bb.cnt_err});
        end
        tests++;
        if ({bb.dump_addr, bb.dump_data, bb.elem_count} !== 92'd0) begin
            fails++;
            $display("FAIL reset_values: got %h want 0", {bb.dump_addr, bb.dump_data, bb.elem_count});
        end
        reset = 1'b0;
        nb = -1;
        no = -1;
        for (int n = 1; n <= 5000 && (nb < 0 || no < 0); n++) begin
            @(negedge clk);
            if (bb.in_ready && nb < 0) nb = n;
            if (bo.in_ready && no < 0) no = n;
        end
        tests++;
        if (nb !== 4096) begin
            fails++;
            $display("FAIL clear_len_big: got %0d want 4096", nb);
        end
        tests++;
        if (no !== 1) begin
            fails++;
            $display("FAIL clear_len_one: got %0d want 1", no);
        end
    endtask

    task automatic test_dump_empty();
        int n, f, l, bad;
        sel = 1'b0;
        run_dump(n, f, l);
        tests++;
        if ({n, f, l} !== {32'd4096, 32'd2, 32'd4097}) begin
            fails++;
            $display("FAIL dump_timing: got beats=%0d first=%0d last=%0d want 4096 2 4097", n, f, l);
        end
        bad = dump_bad();
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL dump_empty: %0d bad beats, got %h want %h", bad, first_bad_got, first_bad_exp);
        end
    endtask

    task automatic test_single_insert();
        int d, dof, rof, n, f, l, bad;
        sel = 1'b0;
        run_elem(32'h12345678, 1'b0, d, dof, rof);
        tests++;
        if (dof !== 2 * d + 2 || rof !== 2 * d + 3) begin
            fails++;
            $display("FAIL insert_latency: got done=%0d ready=%0d want %0d %0d", dof, rof, 2 * d + 2, 2 * d + 3);
        end
        tests++;
        if (ec !== 32'(elems[0])) begin
            fails++;
            $display("FAIL insert_elem_count: got %0d want %0d", ec, elems[0]);
        end
        run_dump(n, f, l);
        bad = dump_bad();
        tests++;
        if (bad !== 0 || n !== 4096) begin
            fails++;
            $display("FAIL insert_dump: %0d bad beats of %0d, got %h want %h", bad, n, first_bad_got, first_bad_exp);
        end
    endtask

    task automatic test_collision();
        int d, dof, rof, n, f, l, bad;
        sel = 1'b1;
        run_elem(32'hA5, 1'b0, d, dof, rof);
        tests++;
        if (dof !== 4 || rof !== 5) begin
            fails++;
            $display("FAIL collision_latency: got done=%0d ready=%0d want 4 5", dof, rof);
        end
        run_dump(n, f, l);
        tests++;
        if ({n, f, l} !== {32'd1, 32'd2, 32'd2}) begin
            fails++;
            $display("FAIL collision_dump_timing: got beats=%0d first=%0d last=%0d want 1 2 2", n, f, l);
        end
        tests++;
        if (got.size() > 0 && got[0][7:0] !== 8'd1) begin
            fails++;
            $display("FAIL collision_count: got %0d want 1", got[0][7:0]);
        end
        bad = dump_bad();
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL collision_dump: got %h want %h", first_bad_got, first_bad_exp);
        end
    endtask

`ifdef IBF_DELETE_EN
    task automatic test_insert_delete();
        int d, dof, rof, n, f, l, bad;
        sel = 1'b0;
        run_elem(32'h12345678, 1'b1, d, dof, rof);
        tests++;
        if (ec !== 32'd2 || err !== 1'b0) begin
            fails++;
            $display("FAIL delete_status: got count=%0d err=%b want 2 0", ec, err);
        end
        run_dump(n, f, l);
        bad = dump_bad();
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL delete_dump: %0d bad beats, got %h want %h", bad, first_bad_got, first_bad_exp);
        end
    endtask

    task automatic test_underflow();
        int d, dof, rof, n, f, l, bad;
        sel = 1'b1;
        run_elem(32'hA5, 1'b1, d, dof, rof);
        run_elem(32'h1, 1'b1, d, dof, rof);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL underflow_err: got %b want 1", err);
        end
        run_dump(n, f, l);
        tests++;
        if (got.size() > 0 && got[0][7:0] !== 8'hFF) begin
            fails++;
            $display("FAIL underflow_count: got %h want ff", got[0][7:0]);
        end
        bad = dump_bad();
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL underflow_dump: got %h want %h", first_bad_got, first_bad_exp);
        end
        run_elem(32'h1, 1'b0, d, dof, rof);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL underflow_sticky: got %b want 1", err);
        end
    endtask
`else
    task automatic test_op_ignored();
        int d, dof, rof, n, f, l, bad;
        sel = 1'b1;
        run_elem(32'h1, 1'b1, d, dof, rof);
        tests++;
        if (err !== 1'b0 || ec !== 32'd2) begin
            fails++;
            $display("FAIL op_ignored_status: got err=%b count=%0d want 0 2", err, ec);
        end
        run_dump(n, f, l);
        tests++;
        if (got.size() > 0 && got[0][7:0] !== 8'd2) begin
            fails++;
            $display("FAIL op_ignored_count: got %0d want 2", got[0][7:0]);
        end
        bad = dump_bad();
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL op_ignored_dump: got %h want %h", first_bad_got, first_bad_exp);
        end
    endtask
`endif

    task automatic test_contention();
        int d, n, acc, dof, bad;
        sel = 1'b0;
        push_expected();
        key = 32'hCAFEF00D;
        op = 1'b0;
        ds = 1'b1;
        v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ds = 1'b0;
        n = 0;
        acc = -1;
        dof = -1;
        for (int j = 1; j <= 4200 && dof < 0; j++) begin
            if (acc >= 0) v = 1'b0;
            if (dv) begin
                got.push_back({da, dd});
                n++;
            end
            if (acc >= 0 && dn) dof = j - acc;
            if (acc < 0 && v && rdy) acc = j;
            @(negedge clk);
        end
        v = 1'b0;
        bad = dump_bad();
        tests++;
        if (bad !== 0 || n !== 4096) begin
            fails++;
            $display("FAIL contention_dump: %0d bad of %0d beats, got %h want %h", bad, n, first_bad_got, first_bad_exp);
        end
        tests++;
        if (acc < 4097 || acc > 4098) begin
            fails++;
            $display("FAIL contention_accept: got cycle %0d want 4097..4098", acc);
        end
        apply(1'b0, 32'hCAFEF00D, 1'b0, d);
        elems[0]++;
        tests++;
        if (dof !== 2 * d + 2 || ec !== 32'(elems[0])) begin
            fails++;
            $display("FAIL contention_elem: got done=%0d count=%0d want %0d %0d", dof, ec, 2 * d + 2, elems[0]);
        end
    endtask

    task automatic test_reset_mid_dump();
        int hit, nb, n, f, l, bad;
        sel = 1'b0;
        ds = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ds = 1'b0;
        hit = 0;
        for (int j = 0; j < 200 && hit == 0; j++) begin
            if (dv && da == 12'd100) hit = 1;
            else @(negedge clk);
        end
        tests++;
        if (hit !== 1) begin
            fails++;
            $display("FAIL mid_dump_beat100: got %0d want 1", hit);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({dv, bsy, rdy, ec} !== {3'b010, 32'd0}) begin
            fails++;
            $display("FAIL mid_dump_reset: got dv=%b busy=%b ready=%b count=%0d want 0 1 0 0", dv, bsy, rdy, ec);
        end
        reset = 1'b0;
        clear_model();
        nb = -1;
        for (int c = 1; c <= 5000 && nb < 0; c++) begin
            @(negedge clk);
            if (rdy) nb = c;
        end
        tests++;
        if (nb !== 4096) begin
            fails++;
            $display("FAIL mid_dump_clear_len: got %0d want 4096", nb);
        end
        run_dump(n, f, l);
        bad = dump_bad();
        tests++;
        if (bad !== 0 || n !== 4096) begin
            fails++;
            $display("FAIL mid_dump_reclear: %0d bad of %0d beats, got %h want %h", bad, n, first_bad_got, first_bad_exp);
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_dump_empty();
        test_single_insert();
        test_collision();
`ifdef IBF_DELETE_EN
        test_insert_delete();
        test_underflow();
`else
        test_op_ignored();
`endif
        test_contention();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ibf_program_engine.md
# ibf_program_engine

Parametrised Invertible Bloom Filter programming engine: accepts a stream of keys and inserts each into, or deletes each from, an on-chip IBF of `CELLS` cells using `K` hash indices. It succeeds the fixed 3-hash, insert-only programmer. It adds handshaked input, optional deletion, and per-element duplicate-index suppression for any `K`. A cycle-accurate dump port replaces file output. It sits between the key source and the IBF subtraction/decoding stage.

## Interface
- `KEY_W`, 32: key field width.
- `SIG_W`, 8: signature field width.
- `CNT_W`, 8: count field width.
- `CELLS`, 4096: number of IBF cells, ≥1.
- `IDX_W`, 12: index width, must satisfy 2^IDX_W ≥ `CELLS`, IDX_W ≤ 32.
- `K`, 3: number of hash indices, 2..8.
- Cell width is `CELL_W = KEY_W+SIG_W+CNT_W`. Layout is {key, sig, count}, with key in the MSBs.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: key offered.
- `in_ready` out 1: engine idle and able to accept.
- `in_key` in KEY_W: key.
- `in_op` in 1: 0 = insert, 1 = delete.
- `done` out 1: one-cycle pulse when an element's update is complete.
- `busy` out 1: high in every state other than IDLE.
- `dump_start` in 1: request a full-table dump.
- `dump_valid` out 1: dump beat valid.
- `dump_addr` out IDX_W: cell address of the dump beat.
- `dump_data` out CELL_W: cell contents of the dump beat.
- `elem_count` out 32: number of completed elements; wraps at 2^32.
- `cnt_err` out 1: sticky count over/underflow flag.

## Operation
- FSM states: CLEAR, IDLE, HASH, RD, WR, DONE, DUMP.
- **CLEAR** (entered on reset): writes zero to cells 0..CELLS-1, one per cycle, then moves to IDLE.
- **IDLE**: `in_ready`=1. On `in_valid`&`in_ready`, latch the key and op, then go to HASH. `dump_start` has priority over `in_valid` when both are high in the same cycle.
- **HASH** (1 cycle):
  - Register the K indices and the signature from `ibf_hash`.
  - Build a dedup mask: index k is active only if idx_k ≠ idx_j for all j<k.
  - Each distinct cell is therefore updated exactly once per element.
- **RD/WR**: for each active k in ascending order, spend one RD cycle (synchronous RAM read) and one WR cycle.
  - Key field ^= key.
  - Sig field ^= sig.
  - Count field ±1, modulo 2^CNT_W.
  - Insert of an all-ones count, or delete of a zero count, sets `cnt_err`.
- **DONE** (1 cycle): `done`=1, `elem_count`+1, then return to IDLE.
- **DUMP**: issue reads for addresses 0..CELLS-1. Each beat appears one cycle after its read. Return to IDLE after the last beat.
- `dump_start` outside IDLE is ignored.
- `in_op` is ignored, and treated as insert, unless `IBF_DELETE_EN` is defined.

## Timing
- Reset values:
  - `in_ready`=0, `busy`=1 (state CLEAR).
  - `done`=0, `dump_valid`=0, `dump_addr`=0, `dump_data`=0.
  - `elem_count`=0, `cnt_err`=0.
- Clear takes CELLS cycles. `in_ready` first rises in cycle CELLS after reset deassertion.
- Per element with D distinct indices (1 ≤ D ≤ K):
  - Acceptance in cycle 0.
  - HASH in cycle 1.
  - RD/WR in cycles 2..2D+1.
  - `done` in cycle 2D+2.
  - `in_ready` back high in cycle 2D+3.
- Dump: beats at addresses 0..CELLS-1 appear in cycles 2..CELLS+1 after `dump_start` acceptance, with `dump_valid` high for exactly CELLS consecutive cycles.
- Reset asserted mid-element or mid-dump: the element in flight is abandoned, `dump_valid` drops at the next edge, and a full CLEAR restarts.
- Hash definitions:
  - h_k = CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection) of `in_key` XOR k.
  - idx_k = h_k[31:32-IDX_W] mod CELLS.
  - sig = h_0[SIG_W-1:0].

## Configuration
- `IBF_DELETE_EN` defined: `in_op`=1 decrements the count; the key and signature XORs are unchanged.
- `IBF_DELETE_EN` undefined: delete logic is absent, every element is an insert, and underflow cannot occur.

## Structure
- Package `ibf_pkg` holds:
  - the CRC-32 polynomial and init constants;
  - the cell field offset functions;
  - the state enum;
  - the op encoding constants (OP_INSERT, OP_DELETE).
- Sub-module `ibf_hash`: purely combinational. Maps the key to K indices plus the signature, and is parameterised by K, IDX_W, CELLS and SIG_W.
- The cell array is inferred as a single-port synchronous RAM in the top level.

## Test plan
- **Reset:** reset, then hold → `in_ready` low for exactly 4096 cycles; dump afterwards → all cells zero.
- **Single insert:** insert key 0x12345678, dump → the D distinct cells each hold {0x12345678, sig, count 1}; all other cells are zero; `elem_count`=1.
- **Full collision (CELLS=1, K=3):** insert key 0xA5 → D=1, `done` 4 cycles after acceptance; cell 0 count=1, not 3.
- **Insert then delete (`IBF_DELETE_EN`):** insert then delete the same key → every cell zero, `elem_count`=2, `cnt_err`=0.
- **Underflow (`IBF_DELETE_EN`, CELLS=1):** delete key 0x1 on an empty table → count 0xFF, `cnt_err`=1 and remaining 1 until reset.
- **Contention and reset mid-dump:** `dump_start` and `in_valid` high in the same cycle → dump runs and the key is accepted afterwards; reset at beat 100 → `dump_valid` low next cycle and CLEAR restarts.
